// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
`timescale 1ns/1ps
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

    localparam int DATA_BITS    = 8;
    localparam int STOP_BITS    = 1;
    localparam int BAUD_DIV_SIM = 16;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock circular FIFO with occupancy count and first-word-fall-through head.
`timescale 1ns/1ps
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [LVL_W-1:0] level,
    output logic             empty,
    output logic             full
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [LVL_W-1:0] level_reg;
    logic             push_ok;
    logic             pop_ok;

    assign empty   = (level_reg == '0);
    assign full    = (level_reg == LVL_W'(DEPTH));
    assign level   = level_reg;
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    // The head is read combinationally so the consumer can capture it on the popping edge.
    assign rdata = mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   level_reg <= level_reg + LVL_W'(1);
                2'b01:   level_reg <= level_reg - LVL_W'(1);
                default: level_reg <= level_reg;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed from a small byte FIFO, with a per-frame latched baud divisor.
`timescale 1ns/1ps
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int DIV_W      = 16,
    localparam int LVL_W     = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic [DIV_W-1:0] baud_div_i,
    input  logic             tx_en_i,
    input  logic [7:0]       wdata_i,
    input  logic             wvalid_i,
    output logic             wready_o,
    output logic             tx_o,
    output logic             busy_o,
    output logic [LVL_W-1:0] fifo_level_o,
    output logic             fifo_empty_o,
    output logic             fifo_full_o
);

    localparam int BIT_W = $clog2(DATA_BITS);

    tx_state_e              state_reg;
    logic [DIV_W-1:0]       div_reg;
    logic [DIV_W-1:0]       cnt_reg;
    logic [BIT_W-1:0]       bit_idx_reg;
    logic [DATA_BITS-1:0]   shift_reg;
    logic                   tx_reg;

    logic [DIV_W-1:0]       div_eff;
    logic [7:0]             fifo_rdata;
    logic                   fifo_empty;
    logic                   fifo_full;
    logic                   fifo_push;
    logic                   fifo_pop;
    logic                   cnt_last;
    logic                   stop_done;
    logic                   frame_go;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (wb_clk_i),
        .srst  (wb_rst_i),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (wdata_i),
        .rdata (fifo_rdata),
        .level (fifo_level_o),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    assign div_eff   = (baud_div_i == '0) ? DIV_W'(1) : baud_div_i;
    assign cnt_last  = (cnt_reg == div_reg - DIV_W'(1));
    assign stop_done = (state_reg == STOP) && cnt_last && (bit_idx_reg == BIT_W'(STOP_BITS - 1));
    assign frame_go  = tx_en_i && !fifo_empty;
    // A new frame starts from IDLE or straight out of the last stop bit, so queued bytes go out gap-free.
    assign fifo_pop  = frame_go && ((state_reg == IDLE) || stop_done);
    assign fifo_push = wvalid_i && !fifo_full;

    assign wready_o     = !fifo_full;
    assign fifo_empty_o = fifo_empty;
    assign fifo_full_o  = fifo_full;
    assign tx_o         = tx_reg;
    assign busy_o       = (state_reg != IDLE);

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_reg   <= IDLE;
            div_reg     <= DIV_W'(1);
            cnt_reg     <= '0;
            bit_idx_reg <= '0;
            shift_reg   <= '0;
            tx_reg      <= 1'b1;
        end else if (fifo_pop) begin
            shift_reg   <= fifo_rdata;
            div_reg     <= div_eff;
            cnt_reg     <= '0;
            bit_idx_reg <= '0;
            state_reg   <= START;
            tx_reg      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    tx_reg <= 1'b1;
                end
                START: begin
                    if (cnt_last) begin
                        cnt_reg     <= '0;
                        bit_idx_reg <= '0;
                        state_reg   <= DATA;
                        tx_reg      <= shift_reg[0];
                    end else begin
                        cnt_reg <= cnt_reg + DIV_W'(1);
                    end
                end
                DATA: begin
                    if (cnt_last) begin
                        cnt_reg <= '0;
                        if (bit_idx_reg == BIT_W'(DATA_BITS - 1)) begin
                            bit_idx_reg <= '0;
                            state_reg   <= STOP;
                            tx_reg      <= 1'b1;
                        end else begin
                            bit_idx_reg <= bit_idx_reg + BIT_W'(1);
                            shift_reg   <= shift_reg >> 1;
                            tx_reg      <= shift_reg[1];
                        end
                    end else begin
                        cnt_reg <= cnt_reg + DIV_W'(1);
                    end
                end
                STOP: begin
                    if (cnt_last) begin
                        cnt_reg <= '0;
                        if (bit_idx_reg == BIT_W'(STOP_BITS - 1)) begin
                            state_reg <= IDLE;
                            tx_reg    <= 1'b1;
                        end else begin
                            bit_idx_reg <= bit_idx_reg + BIT_W'(1);
                        end
                    end else begin
                        cnt_reg <= cnt_reg + DIV_W'(1);
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    tx_reg    <= 1'b1;
                end
            endcase
        end
    end

endmodule
